frac_lut4_cfg_loader: RTL

- Configuration-chain controller for a column of fractured 4-LUT mux blocks.
- Accepts configuration words from the fabric programming interface over a valid/ready handshake.
- Serialises each word LSB-first onto the configuration flip-flop chain (ccff_head) with a per-bit shift enable.
- Counts bits, stops after exactly CHAIN_LEN bits, and reports done.

---
 rtl/frac_lut4_cfg_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/frac_lut4_cfg_loader.sv
// Configuration-chain loader for a column of fractured 4-LUT blocks: takes words over valid/ready
// and shifts them LSB-first onto ccff_head. Optional checksum port: define FRAC_LUT4_CFG_CHKSUM_EN.
module frac_lut4_cfg_loader #(
  parameter int CHAIN_LEN = 136,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef FRAC_LUT4_CFG_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);

  localparam int BDW = $clog2(CHAIN_LEN + 1);
  localparam int WBW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [BDW-1:0]    bits_done_q, bits_done_d;
  logic [WBW-1:0]    wcnt_q, wcnt_d;
  logic [WBW-1:0]    word_bits_q, word_bits_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              err_q, err_d;
  logic [31:0]       rem;
  logic              chain_last, word_last, accept_start, idle_or_done;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_start = start && idle_or_done;
  assign rem          = 32'(CHAIN_LEN) - 32'(bits_done_q);
  assign chain_last   = (bits_done_q == BDW'(CHAIN_LEN - 1));
  assign word_last    = ((wcnt_q + WBW'(1)) == word_bits_q);

  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (cfg_valid) state_d = S_SHIFT;
      // The chain terminal count wins over the per-word count so partial words stop early.
      S_SHIFT: if (chain_last) state_d = S_DONE;
               else if (word_last) state_d = S_LOAD;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == S_LOAD);
    ccff_en   = (state_q == S_SHIFT);
    ccff_head = (state_q == S_SHIFT) && shreg_q[0];
    busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
    done      = (state_q == S_DONE);
    err       = err_q;
  end

  always_comb begin
    bits_done_d = bits_done_q;
    wcnt_d      = wcnt_q;
    word_bits_d = word_bits_q;
    shreg_d     = shreg_q;
    err_d       = err_q;
    if (accept_start) begin
      bits_done_d = '0;
      wcnt_d      = '0;
      err_d       = 1'b0;
    end else if (start && !idle_or_done) begin
      err_d = 1'b1;
    end
    if (state_q == S_LOAD && cfg_valid) begin
      shreg_d     = cfg_data;
      wcnt_d      = '0;
      word_bits_d = (rem < 32'(WORD_W)) ? WBW'(rem) : WBW'(WORD_W);
    end
    if (state_q == S_SHIFT) begin
      shreg_d     = shreg_q >> 1;
      bits_done_d = bits_done_q + BDW'(1);
      wcnt_d      = wcnt_q + WBW'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      bits_done_q <= '0;
      wcnt_q      <= '0;
      word_bits_q <= '0;
      shreg_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      bits_done_q <= bits_done_d;
      wcnt_q      <= wcnt_d;
      word_bits_q <= word_bits_d;
      shreg_q     <= shreg_d;
      err_q       <= err_d;
    end
  end

`ifdef FRAC_LUT4_CFG_CHKSUM_EN
  logic [15:0] chksum_q, chksum_d;

  always_comb begin
    chksum_d = chksum_q;
    if (accept_start)            chksum_d = '0;
    else if (state_q == S_SHIFT) chksum_d = chksum_q + 16'(shreg_q[0]);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) chksum_q <= '0;
    else        chksum_q <= chksum_d;
  end

  assign chksum = chksum_q;
`endif

endmodule
